// File: rtl/conv_ctrl_pkg.sv
// Shared FSM state encoding and counter-width helpers for the 3x3 window controller.
// Build option: CONV_BORDER_OUT_EN (consumed by conv_window_ctrl).
package conv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int col_w(input int row_length);
        return (row_length > 1) ? $clog2(row_length) : 1;
    endfunction

    function automatic int row_w(input int frame_rows);
        return (frame_rows > 1) ? $clog2(frame_rows) : 1;
    endfunction

    // Drain counter has to reach PIPE_LAT, so it needs room for PIPE_LAT+1 values.
    function automatic int drain_w(input int pipe_lat);
        return (pipe_lat > 0) ? $clog2(pipe_lat + 1) : 1;
    endfunction

endpackage

// File: rtl/conv_valid_pipe.sv
// Fixed-depth delay line for {valid, border, x, y}; latency DEPTH cycles, always shifts.
// No backpressure: entries emerge on schedule regardless of upstream gaps.
module conv_valid_pipe #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_dat,
    output logic [W-1:0] o_dat
);

    logic [W-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_dat;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_dat = r_stage[DEPTH-1];

endmodule

// File: rtl/conv_window_ctrl.sv
// Raster sequencer for the 3x3 conv datapath: results valid PIPE_LAT+1 cycles after accept.
// Stalls input (o_ready=0) only while draining at end of frame. Option: CONV_BORDER_OUT_EN.
module conv_window_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int ROW_LENGTH = 1280,
    parameter int FRAME_ROWS = 960,
    parameter int PIPE_LAT   = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    input  logic                          i_sof,
    output logic                          o_ready,
    output logic                          o_shift,
    output logic                          o_out_valid,
    output logic                          o_border,
    output logic [col_w(ROW_LENGTH)-1:0]  o_x,
    output logic [row_w(FRAME_ROWS)-1:0]  o_y,
    output logic                          o_frame_done,
    output logic                          o_sof_err
);

    localparam int XW = col_w(ROW_LENGTH);
    localparam int YW = row_w(FRAME_ROWS);
    localparam int DW = drain_w(PIPE_LAT);
    localparam int PW = 2 + XW + YW;

    localparam logic [XW-1:0] X_LAST = XW'(ROW_LENGTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_ROWS - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);
    localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XW-1:0]   r_col;
    logic [YW-1:0]   r_row;
    logic [DW-1:0]   r_drain;

    logic            w_accept;
    logic            w_counted;
    logic [XW-1:0]   w_c;
    logic [YW-1:0]   w_r;
    logic            w_interior;
    logic            w_ent_vld;
    logic            w_ent_border;
    logic [XW-1:0]   w_ent_x;
    logic [YW-1:0]   w_ent_y;
    logic [PW-1:0]   w_pipe_dat;
    logic            w_pipe_border;
    logic [XW-1:0]   w_pipe_x;
    logic [YW-1:0]   w_pipe_y;

    assign o_ready   = !i_rst && (r_state != DONE);
    assign w_accept  = i_valid && o_ready;
    // Outside a frame only an SOF-qualified pixel is counted; others are dropped.
    assign w_counted = w_accept && ((r_state != IDLE) || i_sof);
    assign o_shift   = w_counted;

    // SOF always restarts the raster at (0,0), including mid-frame restarts.
    assign w_c = i_sof ? '0 : r_col;
    assign w_r = i_sof ? '0 : r_row;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_frame_done = 1'b0;
        o_sof_err    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_counted) begin
                    w_state_nxt = FILL;
                end
            end
            FILL, RUN: begin
                if (w_counted) begin
                    if (i_sof) begin
                        w_state_nxt = FILL;
                        o_sof_err   = 1'b1;
                    end else if ((r_state == FILL) && (w_r == Y_TWO) && (w_c == '0)) begin
                        w_state_nxt = RUN;
                    end else if ((r_state == RUN) && (w_r == Y_LAST) && (w_c == X_LAST)) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (r_drain == D_LAST) begin
                    w_state_nxt  = IDLE;
                    o_frame_done = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_drain <= '0;
        end else begin
            if (w_counted) begin
                if (w_c == X_LAST) begin
                    r_col <= '0;
                    r_row <= (w_r == Y_LAST) ? '0 : w_r + Y_ONE;
                end else begin
                    r_col <= w_c + X_ONE;
                    r_row <= w_r;
                end
            end
            r_drain <= (r_state == DONE) ? r_drain + DW'(1) : '0;
        end
    end

    assign w_interior = (w_r >= Y_TWO) && (w_c >= X_TWO);

`ifdef CONV_BORDER_OUT_EN
    // Every counted pixel yields a window; edge centres clamp to 0.
    assign w_ent_vld    = w_counted;
    assign w_ent_border = w_counted && !w_interior;
    assign w_ent_x      = (w_counted && (w_c != '0)) ? w_c - X_ONE : '0;
    assign w_ent_y      = (w_counted && (w_r != '0)) ? w_r - Y_ONE : '0;
`else
    assign w_ent_vld    = w_counted && w_interior;
    assign w_ent_border = 1'b0;
    assign w_ent_x      = w_ent_vld ? w_c - X_ONE : '0;
    assign w_ent_y      = w_ent_vld ? w_r - Y_ONE : '0;
`endif

    conv_valid_pipe #(
        .DEPTH (PIPE_LAT + 1),
        .W     (PW)
    ) u_valid_pipe (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_dat ({w_ent_vld, w_ent_border, w_ent_x, w_ent_y}),
        .o_dat (w_pipe_dat)
    );

    assign {o_out_valid, w_pipe_border, w_pipe_x, w_pipe_y} = w_pipe_dat;
    assign o_border = o_out_valid && w_pipe_border;
    assign o_x      = o_out_valid ? w_pipe_x : '0;
    assign o_y      = o_out_valid ? w_pipe_y : '0;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed + randomized-gap bench for conv_window_ctrl (8x6 frame, PIPE_LAT=1).
// Reference model works on linear frame position; build with CONV_BORDER_OUT_EN for the border variant.
module tb_conv_window_ctrl;

    localparam int RL   = 8;
    localparam int FR   = 6;
    localparam int PL   = 1;
    localparam int NPIX = RL * FR;

`ifdef CONV_BORDER_OUT_EN
    localparam int EXP_OUT   = NPIX;
    localparam int EXP_BDR   = 24;
    localparam int FIRST_IDX = 0;
    localparam int FIRST_X   = 0;
    localparam int FIRST_Y   = 0;
    localparam int EXP_S3    = 20 + NPIX;
`else
    localparam int EXP_OUT   = 24;
    localparam int EXP_BDR   = 0;
    localparam int FIRST_IDX = 18;
    localparam int FIRST_X   = 1;
    localparam int FIRST_Y   = 1;
    localparam int EXP_S3    = 2 + 24;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_sof = 1'b0;
    logic       o_ready, o_shift, o_out_valid, o_border, o_frame_done, o_sof_err;
    logic [2:0] o_x;
    logic [2:0] o_y;

    conv_window_ctrl #(
        .ROW_LENGTH (RL),
        .FRAME_ROWS (FR),
        .PIPE_LAT   (PL)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .i_sof        (i_sof),
        .o_ready      (o_ready),
        .o_shift      (o_shift),
        .o_out_valid  (o_out_valid),
        .o_border     (o_border),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_frame_done (o_frame_done),
        .o_sof_err    (o_sof_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state: position within the frame and remaining drain cycles.
    bit m_active = 0;
    int m_pos = 0;
    int m_done_left = 0;
    bit m_acc = 0;
    int acc_cyc [NPIX];
    bit e_vld [8];
    bit e_bdr [8];
    int e_x [8];
    int e_y [8];

    int s_out, s_bdr, s_fd, s_shift, s_serr;
    int s_first_cyc, s_first_x, s_first_y, s_last_x, s_last_y, s_fd_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        s_out = 0; s_bdr = 0; s_fd = 0; s_shift = 0; s_serr = 0;
        s_first_cyc = -1; s_first_x = -1; s_first_y = -1;
        s_last_x = -1; s_last_y = -1; s_fd_cyc = -1;
    endtask

    task automatic tick(input logic v, input logic s, input logic r);
        int  sl;
        bit  rdy, acc, cnt, ev, eb;
        int  ex, ey;
        rst = r; i_valid = v; i_sof = s;
        @(negedge clk);
        sl  = cyc % 8;
        rdy = !r && (m_done_left == 0);
        acc = v && rdy;
        cnt = acc && (m_active || s);
        ev  = !r && e_vld[sl];
        eb  = ev && e_bdr[sl];
        ex  = ev ? e_x[sl] : 0;
        ey  = ev ? e_y[sl] : 0;
        chk("ready", o_ready, rdy);
        chk("shift", o_shift, cnt);
        chk("sof_err", o_sof_err, acc && s && m_active);
        chk("frame_done", o_frame_done, !r && (m_done_left == 1));
        chk("out_valid", o_out_valid, ev);
        chk("border", o_border, eb);
        chk("x", o_x, ex);
        chk("y", o_y, ey);
        if (o_out_valid === 1'b1) begin
            if (s_out == 0) begin
                s_first_cyc = cyc; s_first_x = o_x; s_first_y = o_y;
            end
            s_out++;
            s_last_x = o_x; s_last_y = o_y;
            if (o_border === 1'b1) s_bdr++;
        end
        if (o_frame_done === 1'b1) begin s_fd++; s_fd_cyc = cyc; end
        if (o_shift === 1'b1) s_shift++;
        if (o_sof_err === 1'b1) s_serr++;
        e_vld[sl] = 0;
        if (r) begin
            for (int i = 0; i < 8; i++) e_vld[i] = 0;
            m_active = 0; m_pos = 0; m_done_left = 0;
        end else begin
            if (m_done_left > 0) m_done_left--;
            if (cnt) begin
                int  p, rr, cc, ns;
                bit  inter;
                p  = s ? 0 : m_pos;
                rr = p / RL;
                cc = p % RL;
                inter = (rr >= 2) && (cc >= 2);
                ns = (cyc + PL + 1) % 8;
`ifdef CONV_BORDER_OUT_EN
                e_vld[ns] = 1;
                e_bdr[ns] = !inter;
                e_x[ns] = (cc > 0) ? cc - 1 : 0;
                e_y[ns] = (rr > 0) ? rr - 1 : 0;
`else
                if (inter) begin
                    e_vld[ns] = 1; e_bdr[ns] = 0;
                    e_x[ns] = cc - 1; e_y[ns] = rr - 1;
                end
`endif
                acc_cyc[p] = cyc;
                if (p == NPIX - 1) begin
                    m_active = 0; m_pos = 0; m_done_left = PL + 1;
                end else begin
                    m_active = 1; m_pos = p + 1;
                end
            end
        end
        m_acc = acc;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_pixel(input logic s);
        bit done = 0;
        for (int t = 0; t < 20 && !done; t++) begin
            tick(1'b1, s, 1'b0);
            done = m_acc;
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    // gap_mode: 0 back-to-back, 1 valid toggles 1/0, 2 random idle gaps with junk SOF.
    task automatic send_pixels(input int n, input bit first_sof, input int gap_mode);
        for (int i = 0; i < n; i++) begin
            if (gap_mode == 2) begin
                repeat ($urandom_range(0, 2)) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            send_pixel(first_sof && (i == 0));
            if (gap_mode == 1) tick(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int j;
        clear_stats();
        @(posedge clk); #1;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0);

        // Contiguous frame
        clear_stats();
        send_pixels(NPIX, 1, 0);
        idle(4);
        chk("s1_outs", s_out, EXP_OUT);
        chk("s1_border_cnt", s_bdr, EXP_BDR);
        chk("s1_first_x", s_first_x, FIRST_X);
        chk("s1_first_y", s_first_y, FIRST_Y);
        chk("s1_first_time", s_first_cyc, acc_cyc[FIRST_IDX] + 2);
        chk("s1_last_x", s_last_x, 6);
        chk("s1_last_y", s_last_y, 4);
        chk("s1_fd_cnt", s_fd, 1);
        chk("s1_fd_time", s_fd_cyc, acc_cyc[NPIX-1] + 2);

        // Valid toggling
        clear_stats();
        send_pixels(NPIX, 1, 1);
        idle(4);
        chk("s2_outs", s_out, EXP_OUT);
        chk("s2_shifts", s_shift, NPIX);
        chk("s2_last_x", s_last_x, 6);
        chk("s2_fd_cnt", s_fd, 1);

        // SOF reasserted at index 20
        clear_stats();
        send_pixels(20, 1, 0);
        send_pixels(NPIX, 1, 0);
        idle(4);
        chk("s3_sof_err", s_serr, 1);
        chk("s3_outs", s_out, EXP_S3);
        chk("s3_shifts", s_shift, 20 + NPIX);
        chk("s3_fd_cnt", s_fd, 1);

        // Pixels without SOF while idle are dropped
        clear_stats();
        repeat (5) tick(1'b1, 1'b0, 1'b0);
        idle(3);
        chk("s4_shifts", s_shift, 0);
        chk("s4_outs", s_out, 0);
        clear_stats();
        send_pixels(NPIX, 1, 0);
        idle(4);
        chk("s4_outs_after", s_out, EXP_OUT);
        chk("s4_fd_cnt", s_fd, 1);

        // Reset mid-frame
        clear_stats();
        send_pixels(31, 1, 0);
        tick(1'b1, 1'b0, 1'b1);
        idle(3);
        chk("s5_fd_cnt", s_fd, 0);
        clear_stats();
        send_pixels(NPIX, 1, 0);
        idle(4);
        chk("s5_outs", s_out, EXP_OUT);
        chk("s5_first_time", s_first_cyc, acc_cyc[FIRST_IDX] + 2);
        chk("s5_fd_cnt", s_fd, 1);

        // SOF on the final pixel is a restart, not an end of frame
        clear_stats();
        send_pixels(NPIX - 1, 1, 0);
        send_pixels(NPIX, 1, 0);
        idle(4);
        chk("s6_sof_err", s_serr, 1);
        chk("s6_fd_cnt", s_fd, 1);
        chk("s6_shifts", s_shift, 2 * NPIX - 1);

        // Random gaps, then a random mid-frame restart
        for (int k = 0; k < 3; k++) begin
            clear_stats();
            send_pixels(NPIX, 1, 2);
            idle(4);
            chk("s7_outs", s_out, EXP_OUT);
            chk("s7_fd_cnt", s_fd, 1);
        end
        clear_stats();
        j = $urandom_range(1, NPIX - 2);
        send_pixels(j, 1, 2);
        send_pixels(NPIX, 1, 2);
        idle(4);
        chk("s8_sof_err", s_serr, 1);
        chk("s8_fd_cnt", s_fd, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
